streebog_hash_sequencer: RTL and testbench

//  Front-end controller for streebog_hash_top. Accepts a message as a stream of WORD_W-bit words,

---
 rtl/streebog_hash_sequencer.sv | 155 +++++++++++++++
 tb/tb_streebog_hash_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/streebog_hash_sequencer.sv
// Front-end controller for a Streebog (GOST R 34.11-2012) core: packs message words into
// 512-bit blocks, applies the padding rule and sequences init/update/final pulses.
module streebog_hash_sequencer #(
  parameter int WORD_W = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        short_mode,
  output logic                        busy,
  input  logic [WORD_W-1:0]           din,
  input  logic [$clog2(WORD_W/8):0]   din_bytes,
  input  logic                        din_last,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [511:0]                core_block,
  output logic [9:0]                  core_block_length,
  output logic                        core_init,
  output logic                        core_update,
  output logic                        core_final,
  output logic                        core_short_mode,
  input  logic                        core_ready,
  input  logic [511:0]                core_digest,
  input  logic                        core_digest_valid,
  output logic [511:0]                digest,
  output logic                        digest_valid
);

  localparam int WPB = 512 / WORD_W;
  localparam int BPW = WORD_W / 8;
  localparam int IW  = $clog2(WPB) + 1;

  typedef enum logic [2:0] {
    IDLE, INIT, FILL, UPD, UWAIT, PADBLK, FIN, FWAIT
  } state_t;

  state_t          state_q, state_d;
  logic [511:0]    block_q;
  logic [9:0]      len_q;
  logic [IW-1:0]   idx_q;
  logic            more_q;
  logic            pad_q;
  logic            short_q;
  logic [511:0]    digest_q;
  logic            dvalid_q;

  logic [WORD_W-1:0] word_masked;
  logic [10:0]       fill_len;
  logic [511:0]      fill_block;
  logic              block_full;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = INIT;
      INIT:   if (core_ready) state_d = FILL;
      FILL:   if (din_valid && (din_last || block_full)) state_d = UPD;
      UPD:    if (core_ready) state_d = UWAIT;
      UWAIT:  if (core_ready) state_d = more_q ? FILL : (pad_q ? PADBLK : FIN);
      PADBLK: state_d = UPD;
      FIN:    if (core_ready) state_d = FWAIT;
      FWAIT:  if (core_ready && core_digest_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are gated by core_ready so the core is never poked while busy or unreset
  always_comb begin
    busy        = (state_q != IDLE);
    din_ready   = (state_q == FILL);
    core_init   = (state_q == INIT) && core_ready;
    core_update = (state_q == UPD)  && core_ready;
    core_final  = (state_q == FIN)  && core_ready;
  end

  // Incoming word merged into the block, with the padding bit placed right after the data
  always_comb begin
    word_masked = din;
    if (din_last) begin
      for (int k = 0; k < BPW; k++) begin
        if (k >= int'(din_bytes)) word_masked[8*k +: 8] = '0;
      end
    end
    fill_len   = 11'(idx_q) * 11'(WORD_W) + 11'(din_bytes) * 11'd8;
    block_full = (idx_q == IW'(WPB - 1));
    fill_block = block_q;
    fill_block[int'(idx_q)*WORD_W +: WORD_W] = word_masked;
    if (din_last && (fill_len < 11'd512)) fill_block[fill_len[8:0]] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      block_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      more_q   <= 1'b0;
      pad_q    <= 1'b0;
      short_q  <= 1'b0;
      digest_q <= '0;
      dvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          short_q  <= short_mode;
          dvalid_q <= 1'b0;
          block_q  <= '0;
          idx_q    <= '0;
          more_q   <= 1'b0;
          pad_q    <= 1'b0;
        end
        FILL: if (din_valid) begin
          block_q <= fill_block;
          idx_q   <= idx_q + 1'b1;
          if (din_last) begin
            len_q  <= fill_len[9:0];
            more_q <= 1'b0;
            pad_q  <= (fill_len == 11'd512);
          end else if (block_full) begin
            len_q  <= 10'd512;
            more_q <= 1'b1;
            pad_q  <= 1'b0;
          end
        end
        UWAIT: if (core_ready) begin
          block_q <= '0;
          idx_q   <= '0;
        end
        PADBLK: begin
          block_q <= 512'h1;
          len_q   <= '0;
          pad_q   <= 1'b0;
        end
        FWAIT: if (core_ready && core_digest_valid) begin
          digest_q <= short_q ? {core_digest[511:256], 256'b0} : core_digest;
          dvalid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign core_block        = block_q;
  assign core_block_length = len_q;
  assign core_short_mode   = short_q;
  assign digest            = digest_q;
  assign digest_valid      = dvalid_q;

endmodule

// File: tb/tb_streebog_hash_sequencer.sv
// Bench for streebog_hash_sequencer: a stand-in core with variable latency, a padding model
// built from byte arrays, and a per-cycle monitor checking every core pulse against the model.
module tb_streebog_hash_sequencer;

  localparam int WORD_W = 32;
  localparam int BPW    = WORD_W / 8;
  localparam logic [511:0] SEED    = {16{32'h5a3c96e1}};
  localparam logic [511:0] FIN_XOR = {16{32'h0f1e2d3c}};

  logic                       clock = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       start = 1'b0;
  logic                       short_mode = 1'b0;
  logic                       busy;
  logic [WORD_W-1:0]          din = '0;
  logic [$clog2(WORD_W/8):0]  din_bytes = '0;
  logic                       din_last = 1'b0;
  logic                       din_valid = 1'b0;
  logic                       din_ready;
  logic [511:0]               core_block;
  logic [9:0]                 core_block_length;
  logic                       core_init, core_update, core_final, core_short_mode;
  logic                       core_ready = 1'b0;
  logic [511:0]               core_digest = '0;
  logic                       core_digest_valid = 1'b0;
  logic [511:0]               digest;
  logic                       digest_valid;

  int total = 0;
  int bad = 0;

  logic [7:0]   msg [0:255];
  logic [511:0] exp_blk [$];
  logic [9:0]   exp_len [$];
  logic [511:0] act_blk [$];
  logic [9:0]   act_len [$];
  logic [511:0] exp_digest;
  int           n_exp;
  int           n_init = 0, n_upd = 0, n_fin = 0;
  bit           long_lat = 1'b0;

  logic [511:0] acc = '0;
  int           core_cnt = 20;
  bit           fin_pending = 1'b0;

  streebog_hash_sequencer #(.WORD_W(WORD_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .short_mode(short_mode), .busy(busy),
    .din(din), .din_bytes(din_bytes), .din_last(din_last), .din_valid(din_valid),
    .din_ready(din_ready), .core_block(core_block), .core_block_length(core_block_length),
    .core_init(core_init), .core_update(core_update), .core_final(core_final),
    .core_short_mode(core_short_mode), .core_ready(core_ready), .core_digest(core_digest),
    .core_digest_valid(core_digest_valid), .digest(digest), .digest_valid(digest_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [511:0] mix(input logic [511:0] a, input logic [511:0] b,
                                       input logic [9:0] l);
    return {a[510:0], a[511]} ^ b ^ {502'b0, l};
  endfunction

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in core: not reset, ready low at power-up, ready drops for 1..4 cycles per command
  always @(posedge clock) begin
    if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_ready <= 1'b1;
        if (fin_pending) begin
          core_digest       <= acc ^ FIN_XOR;
          core_digest_valid <= 1'b1;
          fin_pending       <= 1'b0;
        end
      end
    end else if (core_ready) begin
      if (core_init) begin
        acc               <= SEED;
        core_digest_valid <= 1'b0;
      end else if (core_update) begin
        acc        <= mix(acc, core_block, core_block_length);
        core_ready <= 1'b0;
        core_cnt   <= long_lat ? 40 : int'($urandom_range(1, 4));
      end else if (core_final) begin
        core_ready        <= 1'b0;
        core_digest_valid <= 1'b0;
        fin_pending       <= 1'b1;
        core_cnt          <= int'($urandom_range(1, 4));
      end
    end
  end

  // Per-cycle monitor: pulse legality and each update checked against the padding model
  always @(negedge clock) begin
    if (reset_n) begin
      total++;
      if ((int'(core_init) + int'(core_update) + int'(core_final) > 1) ||
          (!core_ready && (core_init || core_update || core_final))) begin
        bad++;
        $display("[TB] FAIL pulse_legal: init=%0b upd=%0b fin=%0b ready=%0b required at most one pulse and only when ready",
                 core_init, core_update, core_final, core_ready);
      end
      if (core_init)  n_init++;
      if (core_final) n_fin++;
      if (core_update) begin
        n_upd++;
        act_blk.push_back(core_block);
        act_len.push_back(core_block_length);
        if (exp_blk.size() == 0) begin
          check_output("unexpected_update", 512'(n_upd), 512'(n_exp));
        end else begin
          check_output("update_block", core_block, exp_blk[0]);
          check_output("update_len", 512'(core_block_length), 512'(exp_len[0]));
          void'(exp_blk.pop_front());
          void'(exp_len.pop_front());
        end
      end
    end
  end

  // Padding model: 64-byte chunks, pad bit after the data, extra pad block when exactly full
  task automatic build_model(input int n, input bit short_m);
    int off;
    int rem;
    logic [511:0] blk;
    logic [511:0] a;
    exp_blk.delete();
    exp_len.delete();
    off = 0;
    forever begin
      rem = n - off;
      blk = '0;
      if (rem >= 64) begin
        for (int j = 0; j < 64; j++) blk[8*j +: 8] = msg[off + j];
        exp_blk.push_back(blk);
        exp_len.push_back(10'd512);
        off += 64;
        if (rem == 64) begin
          exp_blk.push_back(512'h1);
          exp_len.push_back(10'd0);
          break;
        end
      end else begin
        for (int j = 0; j < rem; j++) blk[8*j +: 8] = msg[off + j];
        blk[8*rem] = 1'b1;
        exp_blk.push_back(blk);
        exp_len.push_back(10'(8 * rem));
        break;
      end
    end
    n_exp = exp_blk.size();
    a = SEED;
    foreach (exp_blk[i]) a = mix(a, exp_blk[i], exp_len[i]);
    exp_digest = a ^ FIN_XOR;
    if (short_m) exp_digest[255:0] = '0;
  endtask

  task automatic apply_stimulus(input int n, input int seed, input bit short_m,
                                input bit gaps, input bit abort);
    int nw;
    int cyc;
    for (int k = 0; k < 256; k++) msg[k] = 8'(k * 37 + 11 + seed);
    build_model(n, short_m);
    act_blk.delete();
    act_len.delete();
    n_init = 0;
    n_upd  = 0;
    n_fin  = 0;
    @(negedge clock);
    start = 1'b1;
    short_mode = short_m;
    @(negedge clock);
    start = 1'b0;
    short_mode = 1'b0;
    check_output("busy_after_start", 512'(busy), 512'd1);
    check_output("dv_cleared", 512'(digest_valid), 512'd0);
    nw = (n == 0) ? 1 : (n + BPW - 1) / BPW;
    for (int w = 0; w < nw; w++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          din_valid = 1'b0;
          if ($urandom_range(0, 1) == 1) begin
            start = 1'b1;
            short_mode = !short_m;
          end
          @(negedge clock);
          start = 1'b0;
          short_mode = 1'b0;
        end
      end
      for (int k = 0; k < BPW; k++)
        din[8*k +: 8] = (w * BPW + k < n) ? msg[w * BPW + k] : 8'hA5;
      din_last  = (w == nw - 1);
      din_bytes = (w == nw - 1) ? 3'(n - BPW * (nw - 1)) : 3'(BPW);
      din_valid = 1'b1;
      cyc = 0;
      while (!din_ready && cyc < 1000) begin
        @(negedge clock);
        cyc++;
      end
      if (!din_ready) begin
        check_output("din_ready_timeout", 512'(din_ready), 512'd1);
        din_valid = 1'b0;
        din_last  = 1'b0;
        return;
      end
      @(negedge clock);
      din_valid = 1'b0;
      din_last  = 1'b0;
    end
    if (abort) return;
    cyc = 0;
    while (!digest_valid && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    check_output("digest_valid", 512'(digest_valid), 512'd1);
    check_output("digest", digest, exp_digest);
    check_output("busy_done", 512'(busy), 512'd0);
    check_output("n_updates", 512'(n_upd), 512'(n_exp));
    check_output("n_init", 512'(n_init), 512'd1);
    check_output("n_final", 512'(n_fin), 512'd1);
    check_output("core_short_mode", 512'(core_short_mode), 512'(short_m));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check_output("idle_busy", 512'(busy), 512'd0);
    check_output("idle_din_ready", 512'(din_ready), 512'd0);
    check_output("idle_pulses", 512'({core_init, core_update, core_final}), 512'd0);
    check_output("idle_dv", 512'(digest_valid), 512'd0);
    check_output("idle_digest", digest, 512'd0);
    check_output("idle_block", core_block, 512'd0);
    check_output("idle_len", 512'(core_block_length), 512'd0);
    check_output("idle_short", 512'(core_short_mode), 512'd0);

    apply_stimulus(0, 1, 1'b0, 1'b0, 1'b0);
    check_output("empty_count", 512'(act_len.size()), 512'd1);
    if (act_len.size() > 0) begin
      check_output("empty_len", 512'(act_len[0]), 512'd0);
      check_output("empty_block", act_blk[0], 512'h1);
    end

    apply_stimulus(63, 2, 1'b0, 1'b0, 1'b0);
    if (act_len.size() > 0) begin
      check_output("m63_len", 512'(act_len[0]), 512'd504);
      check_output("m63_top", 512'(act_blk[0][511:504]), 512'h01);
    end
    apply_stimulus(63, 2, 1'b1, 1'b0, 1'b0);
    check_output("m63s_low_zero", 512'(digest[255:0]), 512'd0);

    apply_stimulus(64, 3, 1'b0, 1'b0, 1'b0);
    check_output("m64_count", 512'(act_len.size()), 512'd2);
    if (act_len.size() > 1) begin
      check_output("m64_len0", 512'(act_len[0]), 512'd512);
      check_output("m64_len1", 512'(act_len[1]), 512'd0);
      check_output("m64_pad", act_blk[1], 512'h1);
    end

    apply_stimulus(130, 4, 1'b0, 1'b1, 1'b0);
    check_output("m130_count", 512'(act_len.size()), 512'd3);
    if (act_len.size() > 2) begin
      check_output("m130_len0", 512'(act_len[0]), 512'd512);
      check_output("m130_len1", 512'(act_len[1]), 512'd512);
      check_output("m130_len2", 512'(act_len[2]), 512'd16);
      check_output("m130_tail", 512'(act_blk[2][23:0]), 512'(24'h010000 | {8'h0, msg[129], msg[128]}));
    end

    long_lat = 1'b1;
    apply_stimulus(64, 5, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (n_upd < 1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check_output("abort_first_update", 512'(n_upd), 512'd1);
    long_lat = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_output("abort_busy", 512'(busy), 512'd0);
    check_output("abort_din_ready", 512'(din_ready), 512'd0);
    check_output("abort_dv", 512'(digest_valid), 512'd0);
    exp_blk.delete();
    exp_len.delete();
    apply_stimulus(20, 6, 1'b1, 1'b0, 1'b0);
    if (act_len.size() > 0) check_output("after_abort_len", 512'(act_len[0]), 512'd160);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
